truth_table_scorer: RTL

Sequential stimulus and scoring engine for evolved combinational candidate circuits (4-in/4-out gate netlists with #50 gate delays). It sweeps every input vector into the circuit under test and waits a programmable settle time. It then samples the circuit outputs, compares them bit-wise against a target truth table, and accumulates a fitness score plus a per-vector mismatch mask. It is the driving/checking end of the candidate circuit's input0..3/output0..3 interface.

---
 rtl/truth_table_scorer.sv | 111 +++++++++++
 1 files changed

// File: rtl/truth_table_scorer.sv
// Sweeps every input vector into a combinational candidate circuit and scores
// its sampled outputs against a target truth table.
module truth_table_scorer #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned N_OUT         = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    localparam int unsigned N_VEC        = 1 << N_IN,
    localparam int unsigned T_W          = N_OUT * N_VEC,
    localparam int unsigned S_W          = $clog2(T_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [T_W-1:0]   target,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic [S_W-1:0]   score,
    output logic             perfect,
    output logic [N_VEC-1:0] mismatch_mask
);

    localparam int unsigned C_W = 8;
    localparam logic [C_W-1:0]  SETTLE_LOAD = C_W'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [S_W-1:0]  FULL_SCORE  = S_W'(T_W);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t           state;
    logic [T_W-1:0]   target_reg;
    logic [N_IN-1:0]  vec;
    logic [C_W-1:0]   settle_cnt;
    logic [N_OUT-1:0] eq_c;
    logic [S_W-1:0]   eq_cnt_c;

    // Per-bit agreement for the current vector and its population count.
    always_comb begin
        eq_c     = ~(dut_out ^ target_reg[vec*N_OUT +: N_OUT]);
        eq_cnt_c = '0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            eq_cnt_c = eq_cnt_c + S_W'(eq_c[k]);
        end
    end

    // The vector counter doubles as the stimulus driven into the candidate.
    assign dut_in = vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            target_reg    <= '0;
            vec           <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            score         <= '0;
            perfect       <= 1'b0;
            mismatch_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the completion pulse is ignored.
                    if (start && !done) begin
                        target_reg    <= target;
                        score         <= '0;
                        mismatch_mask <= '0;
                        perfect       <= 1'b0;
                        vec           <= '0;
                        settle_cnt    <= SETTLE_LOAD;
                        busy          <= 1'b1;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - C_W'(1);
                    if (settle_cnt <= C_W'(1)) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    score              <= score + eq_cnt_c;
                    mismatch_mask[vec] <= ~&eq_c;
                    if (vec == LAST_VEC) begin
                        state <= FINISH;
                    end else begin
                        vec        <= vec + N_IN'(1);
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    perfect <= (score == FULL_SCORE);
                    vec     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
